mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Sequencing controller that shares one single-ported, variable-latency memory between the CPU's instruction-fetch path and its load/store datapath. It sits between the CPU's instruction-fetch datapath, the data datapath and a unified memory with a req/ack handshake. It serialises accesses, holds the CPU via a stall signal while an access is outstanding, and flags a hung memory with a watchdog.

## Interface
Parameters:
- ADDR_W, 64, address width of both requesters and the memory port
- DATA_W, 64, memory data width; instruction width is fixed at 32
- MAX_WAIT, 15, busy cycles without mem_ack before timeout (1..255)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low; state cleared at any rising edge where reset==0
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_W  fetch address, 4-byte aligned
- if_rdata  out  32  fetched instruction, valid while if_done==1
- if_done  out  1  one-cycle fetch completion pulse
- d_req  in  1  data request, held until d_done
- d_we  in  1  1=store, 0=load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_size  in  4  transfer size in bytes (1/2/4/8), forwarded unchanged
- d_rdata  out  DATA_W  load data, valid while d_done==1
- d_done  out  1  one-cycle data completion pulse
- mem_req  out  1  memory request
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_size  out  4  memory transfer size
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack
- mem_ack  in  1  memory completion, one cycle
- cpu_stall  out  1  CPU must hold PC and pipeline state
- timeout_err  out  1  sticky watchdog error

## Operation
- States: IDLE, IF_BUSY, D_BUSY, ERR.
- IDLE: if d_req is high and d_done is low, go to D_BUSY. This applies whether or not fetch is also pending; data has fixed priority because it belongs to the older instruction. Otherwise, if if_req is high and if_done is low, go to IF_BUSY.
- Entering a BUSY state registers addr, we, wdata and size into the mem_* outputs and sets mem_req. For fetch: mem_we=0 and mem_size=4.
- In BUSY, the mem_* outputs are stable and mem_req stays high until mem_ack is sampled high.
- On the ack edge: mem_req=0, the state returns to IDLE, and the matching done pulse is registered.
  - Fetch data: if_rdata = mem_rdata[31:0] when if_addr[2]==0, else mem_rdata[63:32].
  - Load data: d_rdata = mem_rdata (raw, DATA_W bits).
- A requester whose done is high in the current cycle is not eligible for arbitration in that cycle.
- mem_ack in IDLE or ERR is ignored.
- Watchdog (wait_timer): cleared on BUSY entry, increments each BUSY cycle without ack. When it reaches MAX_WAIT: go to ERR, drop mem_req, set timeout_err; no done pulse is issued.
- ERR is absorbing until reset. cpu_stall=1 in ERR.
- cpu_stall = (if_req & ~if_done) | (d_req & ~d_done) | (state==ERR). This is combinational.

## Timing
- Reset values: state IDLE, every registered output 0 (mem_*, if_rdata, d_rdata, if_done, d_done, timeout_err). Watchdog counter 0.
- Reset mid-access: mem_req is 0 from the reset edge on. No done pulse is issued, and a late ack is ignored.
- Minimum latency: req sampled at edge k → mem_req high after k → zero-wait ack sampled at edge k+1 → done high for cycle k+1..k+2.
- Back-to-back accesses: one IDLE cycle between accesses (the done cycle). Throughput is therefore at most one access every 2 cycles plus memory wait.
- Ack on the same edge the watchdog hits MAX_WAIT: the ack wins and the access completes normally.

## Structure
- Package mem_arb_pkg: state enum typedef (IDLE, IF_BUSY, D_BUSY, ERR), INSTR_BYTES=4 constant, default MAX_WAIT.
- Sub-module wait_timer: clear/enable inputs, reaches-limit output, parameterised by MAX_WAIT. This is the only sub-module.

## Test plan
- Zero-wait fetch: if_req=1, if_addr=0x4, memory acks next cycle with mem_rdata=0x8B020020_91000421 → if_rdata=0x8B020020, if_done high for 1 cycle, 2 cycles after req.
- Conflict: if_req and d_req (load, d_addr=0x10) rise together with 3-cycle memory → data serviced first, d_done, one IDLE cycle, then fetch; exactly two mem_req bursts.
- Store: d_we=1, d_addr=0x28, d_wdata=0xDEADBEEF, d_size=8 → mem_* carry identical values and stay stable across 5 wait cycles until ack; d_done follows the ack.
- Timeout: MAX_WAIT=15, memory never acks → the edge where the counter reaches 15 moves to ERR, mem_req=0, timeout_err=1, cpu_stall=1; a later ack changes nothing.
- Reset mid-access: reset=0 during D_BUSY wait cycle 2 → all outputs 0 at that edge, no d_done; after release, a fresh fetch completes normally.
- Ack/limit tie: ack on the same edge the watchdog reaches MAX_WAIT → normal done, timeout_err stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_BUSY = 2'd1,
    D_BUSY  = 2'd2,
    ERR     = 2'd3
  } arb_state_e;

  // Instruction fetches always move one 32-bit word.
  localparam logic [3:0] INSTR_BYTES = 4'd4;

  // Busy cycles without an acknowledge before the memory is declared hung.
  localparam int unsigned MAX_WAIT_DEFAULT = 15;

endpackage

// File: rtl/wait_timer.sv
// Watchdog counter for an outstanding memory access.
// limit_o flags the edge on which the count would reach MAX_WAIT.
module wait_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic limit_o
);

  localparam logic [7:0] LIMIT = 8'(MAX_WAIT);
  localparam logic [7:0] LAST  = 8'(MAX_WAIT - 1);

  logic [7:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise count enabled cycles and saturate at the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  // Counter register with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign limit_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and load/store,
// data first, with a stall output for the CPU and a sticky hung-memory flag.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W   = 64,
  parameter int unsigned DATA_W   = 64,
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_size,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_size,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              cpu_stall,
  output logic              timeout_err
);

  arb_state_e        state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        mem_size_q, mem_size_d;
  logic [31:0]       if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              if_done_q, if_done_d;
  logic              d_done_q, d_done_d;
  logic              timeout_err_q, timeout_err_d;

  logic busy;
  logic wd_clr;
  logic wd_en;
  logic wd_limit;

  assign busy   = (state_q == IF_BUSY) || (state_q == D_BUSY);
  // Clearing throughout IDLE leaves the counter at zero on every BUSY entry.
  assign wd_clr = (state_q == IDLE);
  assign wd_en  = busy && !mem_ack;

  wait_timer #(
    .MAX_WAIT(MAX_WAIT)
  ) u_wait_timer (
    .clk_i  (clk),
    .rst_ni (reset),
    .clr_i  (wd_clr),
    .en_i   (wd_en),
    .limit_o(wd_limit)
  );

  // Arbitration, access sequencing and completion/timeout handling.
  always_comb begin
    state_d       = state_q;
    mem_req_d     = mem_req_q;
    mem_we_d      = mem_we_q;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    mem_size_d    = mem_size_q;
    if_rdata_d    = if_rdata_q;
    d_rdata_d     = d_rdata_q;
    if_done_d     = 1'b0;
    d_done_d      = 1'b0;
    timeout_err_d = timeout_err_q;

    unique case (state_q)
      IDLE: begin
        if (d_req && !d_done_q) begin
          state_d     = D_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_size_d  = d_size;
        end else if (if_req && !if_done_q) begin
          state_d     = IF_BUSY;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_size_d  = INSTR_BYTES;
        end
      end
      IF_BUSY: begin
        if (mem_ack) begin
          state_d    = IDLE;
          mem_req_d  = 1'b0;
          if_done_d  = 1'b1;
          if_rdata_d = if_addr[2] ? mem_rdata[63:32] : mem_rdata[31:0];
        end else if (wd_limit) begin
          state_d       = ERR;
          mem_req_d     = 1'b0;
          timeout_err_d = 1'b1;
        end
      end
      D_BUSY: begin
        if (mem_ack) begin
          state_d   = IDLE;
          mem_req_d = 1'b0;
          d_done_d  = 1'b1;
          d_rdata_d = mem_rdata;
        end else if (wd_limit) begin
          state_d       = ERR;
          mem_req_d     = 1'b0;
          timeout_err_d = 1'b1;
        end
      end
      ERR: begin
        mem_req_d     = 1'b0;
        timeout_err_d = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, cleared on any edge with reset low.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      mem_size_q    <= '0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
      if_done_q     <= 1'b0;
      d_done_q      <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      mem_size_q    <= mem_size_d;
      if_rdata_q    <= if_rdata_d;
      d_rdata_q     <= d_rdata_d;
      if_done_q     <= if_done_d;
      d_done_q      <= d_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign mem_size    = mem_size_q;
  assign if_rdata    = if_rdata_q;
  assign d_rdata     = d_rdata_q;
  assign if_done     = if_done_q;
  assign d_done      = d_done_q;
  assign timeout_err = timeout_err_q;

  assign cpu_stall = (if_req & ~if_done_q) | (d_req & ~d_done_q) | (state_q == ERR);

endmodule
